// File: rtl/seq_div.sv
// seq_div: iterative radix-2 restoring unsigned divider, one quotient bit per clock.
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   start      : request a division (accepted in IDLE or DONE)
//   dividend   : DIVIDEND_W-bit unsigned dividend, sampled with start
//   divisor    : DIVISOR_W-bit unsigned divisor, sampled with start
//   busy       : high while a division is being computed
//   done       : one-cycle pulse, result valid from this cycle
//   quotient   : registered quotient (all ones on divide by zero)
//   remainder  : registered remainder (zero on divide by zero)
//   div_zero   : registered flag, last accepted divisor was zero
module seq_div #(
   parameter int unsigned DIVIDEND_W = 16,
   parameter int unsigned DIVISOR_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  busy,
   output logic                  done,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_zero
);

   localparam int unsigned CNT_W  = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
   localparam int unsigned TRIAL_W = DIVISOR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [DIVIDEND_W-1:0] dvd_q, dvd_d;     // dividend shifts out MSB-first, quotient bits shift in
   logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
   logic [DIVISOR_W-1:0]  pr_q, pr_d;      // partial remainder, always < divisor between iterations
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [DIVIDEND_W-1:0] quo_q, quo_d;
   logic [DIVISOR_W-1:0]  rem_q, rem_d;
   logic                  dz_q, dz_d;

   logic [TRIAL_W-1:0]    shifted_c;
   logic                  ge_c;
   logic [DIVISOR_W-1:0]  pr_iter_c;
   logic [DIVIDEND_W-1:0] dvd_iter_c;
   logic                  load_c;

   // One restoring step: the extra trial bit keeps the shifted remainder from overflowing.
   always_comb begin
      shifted_c  = {pr_q, dvd_q[DIVIDEND_W-1]};
      ge_c       = (shifted_c >= {1'b0, dsr_q});
      pr_iter_c  = ge_c ? DIVISOR_W'(shifted_c - {1'b0, dsr_q}) : DIVISOR_W'(shifted_c);
      dvd_iter_c = {dvd_q[DIVIDEND_W-2:0], ge_c};
   end

   // Next-state and next-register values.
   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      pr_d    = pr_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dz_d    = dz_q;
      load_c  = 1'b0;

      case (state_q)
         S_IDLE: begin
            load_c = start;
         end
         S_CALC: begin
            dvd_d = dvd_iter_c;
            pr_d  = pr_iter_c;
            cnt_d = CNT_W'(cnt_q - 1'b1);
            if (cnt_q == '0) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               quo_d   = dvd_iter_c;
               // Divide by zero naturally yields all-ones quotient; remainder is forced to 0.
               rem_d   = (dsr_q == '0) ? '0 : pr_iter_c;
               dz_d    = (dsr_q == '0);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            load_c  = start;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      if (load_c) begin
         state_d = S_CALC;
         dvd_d   = dividend;
         dsr_d   = divisor;
         pr_d    = '0;
         cnt_d   = CNT_W'(DIVIDEND_W - 1);
         busy_d  = 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dvd_q  <= '0;
         dsr_q  <= '0;
         pr_q   <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         quo_q  <= '0;
         rem_q  <= '0;
         dz_q   <= 1'b0;
      end else begin
         dvd_q  <= dvd_d;
         dsr_q  <= dsr_d;
         pr_q   <= pr_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         dz_q   <= dz_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign div_zero  = dz_q;

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed-vector table plus hand-written multi-cycle sequences for seq_div.
module tb_seq_div;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        div_zero;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   seq_div #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  b;
      logic [15:0] q;
      logic [7:0]  r;
      logic        dz;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Issue one division from idle; returns at the negedge of the done cycle.
   task automatic run_div(input logic [15:0] a, input logic [7:0] b,
                          output int edges, output int bcnt, output bit to);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      edges = 1;
      bcnt  = 0;
      to    = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy) bcnt++;
         if (done) begin
            to = 1'b0;
            break;
         end
         @(posedge clk);
         edges++;
      end
   endtask

   // Wait (bounded) for a done pulse, sampled on negedges.
   task automatic wait_done(output bit to);
      to = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   initial begin
      int   edges, bcnt, t1, t2;
      bit   to, seen;
      logic [15:0] ra;
      logic [7:0]  rb;

      vecs[0] = '{16'd1000,  8'd7,   16'd142,   8'd6,  1'b0};
      vecs[1] = '{16'd65535, 8'd255, 16'd257,   8'd0,  1'b0};
      vecs[2] = '{16'd65535, 8'd1,   16'd65535, 8'd0,  1'b0};
      vecs[3] = '{16'd5,     8'd9,   16'd0,     8'd5,  1'b0};
      vecs[4] = '{16'd1234,  8'd0,   16'd65535, 8'd0,  1'b1};
      vecs[5] = '{16'd1234,  8'd2,   16'd617,   8'd0,  1'b0};
      vecs[6] = '{16'd255,   8'd16,  16'd15,    8'd15, 1'b0};
      vecs[7] = '{16'd0,     8'd5,   16'd0,     8'd0,  1'b0};
      vecs[8] = '{16'd40000, 8'd123, 16'd325,   8'd25, 1'b0};
      vecs[9] = '{16'd0,     8'd0,   16'd65535, 8'd0,  1'b1};

      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_q",    32'(quotient), 32'd0);
      chk("rst_r",    32'(remainder), 32'd0);
      chk("rst_dz",   32'(div_zero), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed table.
      for (int i = 0; i < 10; i++) begin
         run_div(vecs[i].a, vecs[i].b, edges, bcnt, to);
         chk($sformatf("vec%0d_timeout", i), 32'(to), 32'd0);
         chk($sformatf("vec%0d_q", i), 32'(quotient), 32'(vecs[i].q));
         chk($sformatf("vec%0d_r", i), 32'(remainder), 32'(vecs[i].r));
         chk($sformatf("vec%0d_dz", i), 32'(div_zero), 32'(vecs[i].dz));
         chk($sformatf("vec%0d_latency", i), 32'(edges), 32'd17);
         chk($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd16);
         chk($sformatf("vec%0d_busy_in_done", i), 32'(busy), 32'd0);
      end

      // start while busy is ignored.
      @(negedge clk);
      dividend = 16'd60000; divisor = 8'd200; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1 start = 1'b1; dividend = 16'd100; divisor = 8'd3;
      @(posedge clk);
      #1 start = 1'b0; dividend = '0; divisor = '0;
      wait_done(to);
      chk("ign_timeout", 32'(to), 32'd0);
      chk("ign_q", 32'(quotient), 32'd300);
      chk("ign_r", 32'(remainder), 32'd0);
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      chk("ign_no_extra_activity", 32'(seen), 32'd0);
      chk("ign_q_stable", 32'(quotient), 32'd300);
      chk("ign_r_stable", 32'(remainder), 32'd0);

      // start held through DONE: back-to-back 200/9 then 77/7.
      @(negedge clk);
      dividend = 16'd200; divisor = 8'd9; start = 1'b1;
      wait_done(to);
      t1 = cyc;
      chk("b2b1_timeout", 32'(to), 32'd0);
      chk("b2b1_q", 32'(quotient), 32'd22);
      chk("b2b1_r", 32'(remainder), 32'd2);
      dividend = 16'd77; divisor = 8'd7;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("b2b_accept_busy", 32'(busy), 32'd1);
      chk("b2b_done_one_cycle", 32'(done), 32'd0);
      chk("b2b_hold_q", 32'(quotient), 32'd22);
      wait_done(to);
      t2 = cyc;
      chk("b2b2_timeout", 32'(to), 32'd0);
      chk("b2b2_q", 32'(quotient), 32'd11);
      chk("b2b2_r", 32'(remainder), 32'd0);
      chk("b2b_spacing", 32'(t2 - t1), 32'd17);

      // Asynchronous reset mid-calculation.
      @(negedge clk);
      dividend = 16'd1000; divisor = 8'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_q", 32'(quotient), 32'd0);
      chk("arst_r", 32'(remainder), 32'd0);
      chk("arst_dz", 32'(div_zero), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      chk("arst_no_done", 32'(seen), 32'd0);
      run_div(16'd50, 8'd5, edges, bcnt, to);
      chk("arst_next_timeout", 32'(to), 32'd0);
      chk("arst_next_q", 32'(quotient), 32'd10);
      chk("arst_next_r", 32'(remainder), 32'd0);
      chk("arst_next_latency", 32'(edges), 32'd17);

      // Random sweep against the division invariant.
      for (int i = 0; i < 2000; i++) begin
         ra = 16'($urandom_range(0, 65535));
         rb = 8'($urandom_range(0, 255));
         if (i % 50 == 0) rb = 8'd0;
         run_div(ra, rb, edges, bcnt, to);
         chk("rand_timeout", 32'(to), 32'd0);
         if (rb == 8'd0) begin
            chk("rand_dz_q", 32'(quotient), 32'd65535);
            chk("rand_dz_r", 32'(remainder), 32'd0);
            chk("rand_dz_flag", 32'(div_zero), 32'd1);
         end else begin
            chk("rand_inv", 32'(quotient) * 32'(rb) + 32'(remainder), 32'(ra));
            chk("rand_r_lt_b", 32'(remainder < rb), 32'd1);
            chk("rand_dz_flag", 32'(div_zero), 32'd0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
